// File: rtl/mash_pkg.sv
// Shared definitions for the MASH 1-1-1 frequency-hop sequencer:
// word widths, hop-table entry layout, FSM states and dither LFSR constants.
package mash_pkg;

    localparam int MASH_INT_W   = 4;
    localparam int MASH_FRAC_W  = 16;
    localparam int MASH_DWELL_W = 16;

    // One hop: integer and fractional divider words plus dwell time in cycles
    typedef struct packed {
        logic [MASH_INT_W-1:0]   int_word;
        logic [MASH_FRAC_W-1:0]  frac_word;
        logic [MASH_DWELL_W-1:0] dwell;
    } hop_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form:
    // feedback taken from bits 0, 2, 3 and 5
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/mash_hop_table.sv
// Hop table register file: one synchronous write port, one combinational
// read port. A read and write to the same entry in one cycle returns the
// old contents. Contents are intentionally not reset.
module mash_hop_table
    import mash_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  hop_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output hop_entry_t    rdata
);

    hop_entry_t mem [DEPTH];

    // Table write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mash_freq_sequencer.sv
// Frequency-hop controller for the MASH 1-1-1 fractional-N core.
// Steps through a table of {int, frac, dwell} words under start/stop control,
// drives the core inputs and clears the core at the start of each sequence.
// Optional build macro MASH_SEQ_DITHER_EN: dithers mash_in_f[0] with a 16-bit
// LFSR seeded with 16'hACE1 at reset and at each start.
module mash_freq_sequencer
    import mash_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int INT_W   = MASH_INT_W,
    parameter int FRAC_W  = MASH_FRAC_W,
    parameter int DWELL_W = MASH_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [INT_W-1:0]   cfg_int,
    input  logic [FRAC_W-1:0]  cfg_frac,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [AW-1:0]      last_idx,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic               hop_strb,
    output logic [AW-1:0]      cur_idx,
    output logic [INT_W-1:0]   mash_in_i,
    output logic [FRAC_W-1:0]  mash_in_f,
    output logic               mash_clr_n
);

    localparam logic [AW-1:0] MAX_IDX = AW'(DEPTH - 1);

    seq_state_t         state;
    logic [AW-1:0]      idx;
    logic [AW-1:0]      last_c;
    logic [AW-1:0]      load_idx;
    logic               load_go;
    logic [DWELL_W-1:0] cnt;
    logic [FRAC_W-1:0]  frac_q;
    hop_entry_t         wentry;
    hop_entry_t         rentry;

    assign wentry.int_word  = cfg_int;
    assign wentry.frac_word = cfg_frac;
    assign wentry.dwell     = cfg_dwell;

    mash_hop_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk   (clk),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (wentry),
        .raddr (load_idx),
        .rdata (rentry)
    );

    assign last_c = (last_idx > MAX_IDX) ? MAX_IDX : last_idx;

    // Decide whether a new word is fetched this cycle and from which entry
    always_comb begin
        load_go  = 1'b0;
        load_idx = '0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    load_go = 1'b1;
                end
            end
            DWELL: begin
                if (!stop && cnt <= DWELL_W'(1)) begin
                    if (idx < last_c) begin
                        load_go  = 1'b1;
                        load_idx = idx + 1'b1;
                    end else if (loop_en) begin
                        load_go = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Sequencer FSM: new words are registered as the FSM enters LOAD, so
    // hop_strb and the word appear together during the LOAD cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hop_strb   <= 1'b0;
            cur_idx    <= '0;
            mash_in_i  <= '0;
            frac_q     <= '0;
            mash_clr_n <= 1'b0;
        end else begin
            hop_strb   <= 1'b0;
            done       <= 1'b0;
            mash_clr_n <= 1'b1;
            if (load_go) begin
                state     <= LOAD;
                busy      <= 1'b1;
                idx       <= load_idx;
                cur_idx   <= load_idx;
                mash_in_i <= rentry.int_word;
                frac_q    <= rentry.frac_word;
                cnt       <= (rentry.dwell == '0) ? DWELL_W'(1) : rentry.dwell;
                hop_strb  <= 1'b1;
                // Core clear only on a fresh start, never on a loop wrap
                if (state == IDLE) begin
                    mash_clr_n <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: ;
                    LOAD: begin
                        if (stop) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DWELL;
                        end
                    end
                    DWELL: begin
                        if (stop) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (cnt <= DWELL_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        done  <= !stop;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef MASH_SEQ_DITHER_EN
    logic [15:0] lfsr;
    logic        dith_on;

    // Dither LFSR: free-running, reseeded on each accepted start; dithering
    // begins with the first applied word so reset outputs stay at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr    <= LFSR_SEED;
            dith_on <= 1'b0;
        end else if (load_go && state == IDLE) begin
            lfsr    <= LFSR_SEED;
            dith_on <= 1'b1;
        end else begin
            lfsr    <= lfsr_step(lfsr);
        end
    end

    assign mash_in_f = {frac_q[FRAC_W-1:1], frac_q[0] ^ (lfsr[0] & dith_on)};
`else
    assign mash_in_f = frac_q;
`endif

endmodule

// File: tb/tb_mash_freq_sequencer.sv
// Directed bench for mash_freq_sequencer. Cycle k of a sequence is the
// period after the k-th rising edge following the cycle start is applied.
module tb_mash_freq_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [3:0]  cfg_int;
    logic [15:0] cfg_frac;
    logic [15:0] cfg_dwell;
    logic [2:0]  last_idx;
    logic        loop_en;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic        hop_strb;
    logic [2:0]  cur_idx;
    logic [3:0]  mash_in_i;
    logic [15:0] mash_in_f;
    logic        mash_clr_n;

    int vectors = 0;
    int miscompares = 0;

    mash_freq_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_int    (cfg_int),
        .cfg_frac   (cfg_frac),
        .cfg_dwell  (cfg_dwell),
        .last_idx   (last_idx),
        .loop_en    (loop_en),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .hop_strb   (hop_strb),
        .cur_idx    (cur_idx),
        .mash_in_i  (mash_in_i),
        .mash_in_f  (mash_in_f),
        .mash_clr_n (mash_clr_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [3:0] i,
                               input logic [15:0] f, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_int = i; cfg_frac = f; cfg_dwell = d;
        tick();
        cfg_we = 1'b0;
    endtask

    function automatic logic [15:0] model_lfsr(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    task automatic test_reset();
        logic [30:0] got;
        rst = 1'b1;
        tick(); tick();
        got = {busy, done, hop_strb, cur_idx, mash_in_i, mash_in_f, mash_clr_n, 3'b000};
        vectors++;
        if (got !== 31'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h want=0", got);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (mash_clr_n !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release clr_n=%b busy=%b want clr_n=1 busy=0", mash_clr_n, busy);
        end
    endtask

    task automatic test_one_shot();
        logic [3:0] got, exp;
        logic [22:0] wgot, wexp;
        last_idx = 3'd2; loop_en = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            start = 1'b0;
            exp = {(c == 1 || c == 5 || c == 8), (c == 11), (c <= 9), (c != 1)};
            got = {hop_strb, done, busy, mash_clr_n};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL one_shot_ctrl c=%0d hop/done/busy/clr got=%b want=%b", c, got, exp);
            end
            if (c >= 8)      wexp = {3'd2, 4'd7, 16'hC000};
            else if (c >= 5) wexp = {3'd1, 4'd6, 16'h8000};
            else             wexp = {3'd0, 4'd5, 16'h4000};
            wgot = {cur_idx, mash_in_i, mash_in_f};
`ifdef MASH_SEQ_DITHER_EN
            wgot[0] = 1'b0;
`endif
            vectors++;
            if (wgot !== wexp) begin
                miscompares++;
                $display("FAIL one_shot_word c=%0d idx/int/frac got=%h want=%h", c, wgot, wexp);
            end
        end
    endtask

    task automatic test_loop();
        logic [2:0] got, exp;
        last_idx = 3'd2; loop_en = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            start = 1'b0;
            exp = {(c == 1 || c == 5 || c == 8 || c == 10 || c == 14 || c == 17 || c == 19),
                   1'b0, (c != 1)};
            got = {hop_strb, done, mash_clr_n};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL loop_ctrl c=%0d hop/done/clr got=%b want=%b", c, got, exp);
            end
            if (c == 10 || c == 19) begin
                vectors++;
                if (cur_idx !== 3'd0 || mash_in_i !== 4'd5) begin
                    miscompares++;
                    $display("FAIL loop_wrap c=%0d idx=%0d int=%0d want idx=0 int=5", c, cur_idx, mash_in_i);
                end
            end
        end
        stop = 1'b1; tick(); stop = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL loop_stop busy=%b done=%b want 0 0", busy, done);
        end
        tick();
    endtask

    task automatic test_dwell_zero();
        logic [2:0] got, exp;
        write_entry(3'd1, 4'd6, 16'h8000, 16'd0);
        last_idx = 3'd2; loop_en = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            start = 1'b0;
            exp = {(c == 1 || c == 5 || c == 7), (c == 10), (c <= 8)};
            got = {hop_strb, done, busy};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL dwell_zero c=%0d hop/done/busy got=%b want=%b", c, got, exp);
            end
        end
        write_entry(3'd1, 4'd6, 16'h8000, 16'd2);
    endtask

    task automatic test_stop();
        logic [13:0] got, exp;
        last_idx = 3'd2; loop_en = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start = 1'b0;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int c = 7; c <= 11; c++) begin
            got = {busy, done, hop_strb, cur_idx, mash_in_i, mash_in_f[15:12]};
            exp = {3'b000, 3'd1, 4'd6, 4'h8};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL stop_hold c=%0d got=%h want=%h", c, got, exp);
            end
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (mash_clr_n !== 1'b0 || hop_strb !== 1'b1 || cur_idx !== 3'd0 || mash_in_i !== 4'd5) begin
            miscompares++;
            $display("FAIL stop_restart clr=%b hop=%b idx=%0d int=%0d want 0 1 0 5",
                     mash_clr_n, hop_strb, cur_idx, mash_in_i);
        end
        stop = 1'b1; tick(); stop = 1'b0; tick();
    endtask

    task automatic test_start_stop_conflict();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        vectors++;
        if (busy !== 1'b0 || hop_strb !== 1'b0 || mash_clr_n !== 1'b1) begin
            miscompares++;
            $display("FAIL start_and_stop busy=%b hop=%b clr=%b want 0 0 1", busy, hop_strb, mash_clr_n);
        end
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        vectors++;
        if (mash_clr_n !== 1'b1 || busy !== 1'b1 || hop_strb !== 1'b0 || cur_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL start_busy c=4 clr=%b busy=%b hop=%b idx=%0d want 1 1 0 0",
                     mash_clr_n, busy, hop_strb, cur_idx);
        end
        tick();
        vectors++;
        if (hop_strb !== 1'b1 || cur_idx !== 3'd1) begin
            miscompares++;
            $display("FAIL start_busy c=5 hop=%b idx=%0d want 1 1", hop_strb, cur_idx);
        end
        stop = 1'b1; tick(); stop = 1'b0; tick();
    endtask

    task automatic test_write_during_load();
        logic [15:0] lf;
        last_idx = 3'd2; loop_en = 1'b1;
        lf = 16'hACE1;
        start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            if (c == 5) begin
                cfg_we = 1'b1; cfg_addr = 3'd1; cfg_int = 4'd9; cfg_frac = 16'h1234; cfg_dwell = 16'd2;
            end
            tick();
            start = 1'b0;
            cfg_we = 1'b0;
            // All table fractions are even, so bit 0 shows only the dither
            vectors++;
`ifdef MASH_SEQ_DITHER_EN
            if (mash_in_f[0] !== lf[0]) begin
                miscompares++;
                $display("FAIL dither_bit c=%0d got=%b want=%b", c, mash_in_f[0], lf[0]);
            end
`else
            if (mash_in_f[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL frac_bit0 c=%0d got=%b want=0", c, mash_in_f[0]);
            end
`endif
            lf = model_lfsr(lf);
            if (c == 5) begin
                vectors++;
                if (hop_strb !== 1'b1 || cur_idx !== 3'd1 || mash_in_i !== 4'd6 || mash_in_f[15:1] !== 15'h4000) begin
                    miscompares++;
                    $display("FAIL rbw_old hop=%b idx=%0d int=%0d frac=%h want 1 1 6 8000",
                             hop_strb, cur_idx, mash_in_i, mash_in_f);
                end
            end
            if (c == 14) begin
                vectors++;
                if (hop_strb !== 1'b1 || cur_idx !== 3'd1 || mash_in_i !== 4'd9 || mash_in_f[15:1] !== 15'h091A) begin
                    miscompares++;
                    $display("FAIL rbw_new hop=%b idx=%0d int=%0d frac=%h want 1 1 9 1234",
                             hop_strb, cur_idx, mash_in_i, mash_in_f);
                end
            end
        end
        stop = 1'b1; tick(); stop = 1'b0; tick();
    endtask

    task automatic test_reset_mid_sequence();
        loop_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        vectors++;
        if ({busy, hop_strb, cur_idx, mash_in_i, mash_in_f, mash_clr_n} !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_mid busy=%b hop=%b idx=%0d int=%0d frac=%h clr=%b want all 0",
                     busy, hop_strb, cur_idx, mash_in_i, mash_in_f, mash_clr_n);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_int = '0; cfg_frac = '0; cfg_dwell = '0;
        last_idx = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        test_reset();
        write_entry(3'd0, 4'd5, 16'h4000, 16'd3);
        write_entry(3'd1, 4'd6, 16'h8000, 16'd2);
        write_entry(3'd2, 4'd7, 16'hC000, 16'd1);
        test_one_shot();
        test_loop();
        test_dwell_zero();
        test_stop();
        test_start_stop_conflict();
        test_write_during_load();
        test_reset_mid_sequence();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
